// File: rtl/icache_refill_drive.sv
// Fetch-stage result driver with I-cache refill: forwards hits directly, refills misses with an
// AXI4 wrapping burst (critical word first) and writes the finished line into an LFSR-picked way.
module icache_refill_drive #(
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned WAYS       = 8,
   parameter int unsigned INDEX_W    = 4,
   parameter int unsigned AXI_ID     = 0,
   localparam int unsigned BEAT_W    = $clog2(LINE_WORDS),
   localparam int unsigned OFF_W     = BEAT_W + 2,
   localparam int unsigned TAG_W     = 32 - INDEX_W - OFF_W,
   localparam int unsigned LINE_W    = 32 * LINE_WORDS,
   localparam int unsigned WAY_W     = $clog2(WAYS)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                valid_pre_i,
   output logic                ready_pre_o,
   input  logic [31:0]         pc_i,
   input  logic                hit_i,
   input  logic [LINE_W-1:0]   hit_line_i,
   output logic                valid_post_o,
   input  logic                ready_post_i,
   input  logic                flush_i,
   output logic [31:0]         pc_o,
   output logic [31:0]         inst_o,
   output logic                fault_o,
   output logic                wen_o,
   output logic [INDEX_W-1:0]  windex_o,
   output logic [WAY_W-1:0]    wway_o,
   output logic [TAG_W-1:0]    wtag_o,
   output logic [LINE_W-1:0]   wdata_o,
   output logic                io_master_arvalid,
   input  logic                io_master_arready,
   output logic [31:0]         io_master_araddr,
   output logic [3:0]          io_master_arid,
   output logic [7:0]          io_master_arlen,
   output logic [2:0]          io_master_arsize,
   output logic [1:0]          io_master_arburst,
   input  logic                io_master_rvalid,
   output logic                io_master_rready,
   input  logic [1:0]          io_master_rresp,
   input  logic [31:0]         io_master_rdata,
   input  logic                io_master_rlast,
   input  logic [3:0]          io_master_rid
);

   typedef enum logic [2:0] {StIdle, StHit, StAr, StR, StWrite, StHold, StDrain} state_e;

   state_e              state_q;
   logic [31:0]         pc_q;
   logic [LINE_W-1:0]   line_q;
   logic [BEAT_W-1:0]   beat_q;
   logic                inst_pending_q;
   logic                inst_sent_q;
   logic                fault_q;
   logic                err_q;
   logic                flush_pend_q;
   logic [7:0]          lfsr_q;
   logic [WAY_W-1:0]    way_q;

   logic [BEAT_W-1:0]   start;
   logic [BEAT_W-1:0]   word_idx;
   logic                st_ar;
   logic                valid_raw;
   logic                xfer;
   logic                beat_err;
   logic                lfsr_fb;
   logic                unused_rid;

   assign start    = pc_q[OFF_W-1:2];
   assign word_idx = start + beat_q;
   assign st_ar    = (state_q == StAr);
   assign beat_err = (io_master_rresp != 2'b00);
   assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
   assign unused_rid = ^io_master_rid;

   // The requested word always lives at line word `start`, for hits and refills alike.
   assign valid_raw = (state_q == StHit) ||
                      (((state_q == StR) || (state_q == StWrite) || (state_q == StHold)) &&
                       inst_pending_q && !inst_sent_q);
   assign valid_post_o = valid_raw && !flush_i;
   assign xfer         = valid_post_o && ready_post_i;
   assign ready_pre_o  = (state_q == StIdle);
   assign pc_o         = pc_q;
   assign inst_o       = line_q[start*32 +: 32];
   assign fault_o      = fault_q && valid_post_o;

   assign wen_o    = (state_q == StWrite);
   assign windex_o = pc_q[OFF_W +: INDEX_W];
   assign wtag_o   = pc_q[31 -: TAG_W];
   assign wway_o   = way_q;
   assign wdata_o  = line_q;

   assign io_master_arvalid = st_ar;
   assign io_master_araddr  = st_ar ? {pc_q[31:2], 2'b00} : '0;
   assign io_master_arid    = st_ar ? 4'(AXI_ID) : '0;
   assign io_master_arlen   = st_ar ? 8'(LINE_WORDS - 1) : '0;
   assign io_master_arsize  = st_ar ? 3'b010 : '0;
   assign io_master_arburst = st_ar ? 2'b10 : '0;
   assign io_master_rready  = (state_q == StR) || (state_q == StDrain);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         pc_q           <= '0;
         line_q         <= '0;
         beat_q         <= '0;
         inst_pending_q <= 1'b0;
         inst_sent_q    <= 1'b0;
         fault_q        <= 1'b0;
         err_q          <= 1'b0;
         flush_pend_q   <= 1'b0;
         lfsr_q         <= 8'h01;
         way_q          <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (valid_pre_i) begin
                  pc_q           <= pc_i;
                  line_q         <= hit_line_i;
                  inst_pending_q <= 1'b0;
                  inst_sent_q    <= 1'b0;
                  fault_q        <= 1'b0;
                  err_q          <= 1'b0;
                  flush_pend_q   <= 1'b0;
                  beat_q         <= '0;
                  state_q        <= hit_i ? StHit : StAr;
               end
            end
            StHit: begin
               if (flush_i || ready_post_i) state_q <= StIdle;
            end
            StAr: begin
               // arvalid stays up until the handshake; a flush only redirects the burst to DRAIN.
               if (flush_i) flush_pend_q <= 1'b1;
               if (io_master_arready) begin
                  lfsr_q  <= {lfsr_q[6:0], lfsr_fb};
                  way_q   <= lfsr_q[WAY_W-1:0];
                  state_q <= (flush_i || flush_pend_q) ? StDrain : StR;
               end
            end
            StR: begin
               if (flush_i) begin
                  beat_q  <= '0;
                  state_q <= (io_master_rvalid && io_master_rlast) ? StIdle : StDrain;
               end else begin
                  if (xfer) inst_sent_q <= 1'b1;
                  if (io_master_rvalid) begin
                     line_q[word_idx*32 +: 32] <= io_master_rdata;
                     beat_q <= beat_q + BEAT_W'(1);
                     if (beat_q == '0) begin
                        inst_pending_q <= 1'b1;
                        fault_q        <= beat_err;
                     end
                     if (beat_err) err_q <= 1'b1;
                     if (io_master_rlast) begin
                        beat_q  <= '0;
                        state_q <= (err_q || beat_err) ? StHold : StWrite;
                     end
                  end
               end
            end
            StWrite: begin
               if (xfer) inst_sent_q <= 1'b1;
               state_q <= flush_i ? StIdle : StHold;
            end
            StHold: begin
               if (flush_i || inst_sent_q || xfer) state_q <= StIdle;
            end
            StDrain: begin
               if (io_master_rvalid && io_master_rlast) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_refill_drive.sv
// Directed + randomized bench for icache_refill_drive with an inline AXI read slave and a
// behavioural model of line assembly, way selection and handshake outcomes.
module tb_icache_refill_drive;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          valid_pre_i = 1'b0;
   logic          ready_pre_o;
   logic [31:0]   pc_i = '0;
   logic          hit_i = 1'b0;
   logic [127:0]  hit_line_i = '0;
   logic          valid_post_o;
   logic          ready_post_i = 1'b0;
   logic          flush_i = 1'b0;
   logic [31:0]   pc_o;
   logic [31:0]   inst_o;
   logic          fault_o;
   logic          wen_o;
   logic [3:0]    windex_o;
   logic [2:0]    wway_o;
   logic [23:0]   wtag_o;
   logic [127:0]  wdata_o;
   logic          arvalid;
   logic          arready = 1'b0;
   logic [31:0]   araddr;
   logic [3:0]    arid;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          rvalid = 1'b0;
   logic          rready;
   logic [1:0]    rresp = '0;
   logic [31:0]   rdata = '0;
   logic          rlast = 1'b0;
   logic [3:0]    rid = '0;

   int checks = 0;
   int errors = 0;
   int wen_cnt = 0;
   int xfer_cnt = 0;
   logic [7:0] lfsr_m = 8'h01;

   icache_refill_drive #(
      .LINE_WORDS(4), .WAYS(8), .INDEX_W(4), .AXI_ID(0)
   ) dut (
      .clock(clock), .reset(reset),
      .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o), .pc_i(pc_i), .hit_i(hit_i),
      .hit_line_i(hit_line_i), .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
      .flush_i(flush_i), .pc_o(pc_o), .inst_o(inst_o), .fault_o(fault_o), .wen_o(wen_o),
      .windex_o(windex_o), .wway_o(wway_o), .wtag_o(wtag_o), .wdata_o(wdata_o),
      .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
      .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
      .io_master_arburst(arburst), .io_master_rvalid(rvalid), .io_master_rready(rready),
      .io_master_rresp(rresp), .io_master_rdata(rdata), .io_master_rlast(rlast),
      .io_master_rid(rid)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (wen_o) wen_cnt <= wen_cnt + 1;
      if (valid_post_o && ready_post_i) xfer_cnt <= xfer_cnt + 1;
   end

   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      int fb;
      fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
      return 8'(((l << 1) | fb) & 8'hff);
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_hit(input logic [31:0] pc, input int stall, input bit fl);
      logic [127:0] line;
      int s, x0, w0;
      line = {$urandom, $urandom, $urandom, $urandom};
      s = (pc >> 2) % 4;
      x0 = xfer_cnt;
      w0 = wen_cnt;
      chk("hit_idle_ready", ready_pre_o, 1);
      valid_pre_i = 1; pc_i = pc; hit_i = 1; hit_line_i = line;
      ready_post_i = (stall == 0);
      tick;
      valid_pre_i = 0; hit_i = 0; hit_line_i = '0;
      if (fl) begin
         flush_i = 1;
         #1 chk("hit_flush_valid", valid_post_o, 0);
         tick;
         flush_i = 0;
         #1 chk("hit_flush_idle", ready_pre_o, 1);
         chk("hit_flush_xfer", xfer_cnt - x0, 0);
         return;
      end
      #1;
      chk("hit_valid", valid_post_o, 1);
      chk("hit_inst", inst_o, line[s*32 +: 32]);
      chk("hit_pc", pc_o, pc);
      chk("hit_fault", fault_o, 0);
      chk("hit_no_ar", arvalid, 0);
      for (int i = 0; i < stall; i++) begin
         tick;
         chk("hit_stall_valid", valid_post_o, 1);
         chk("hit_stall_inst", inst_o, line[s*32 +: 32]);
      end
      ready_post_i = 1;
      tick;
      chk("hit_back_idle", ready_pre_o, 1);
      chk("hit_xfer_count", xfer_cnt - x0, 1);
      chk("hit_no_wen", wen_cnt - w0, 0);
   endtask

   // flush_at: -1 none, -2 during the AR wait, k>=0 on beat k (only 0/1 used)
   task automatic do_miss(input logic [31:0] pc, input int ar_wait, input int flush_at,
                          input logic [1:0] r0, input logic [1:0] r2, input int stall);
      logic [31:0]  d [4];
      logic [31:0]  w [4];
      logic [127:0] exp_line;
      logic [2:0]   exp_way;
      int start, w0, x0, n;
      bit killed, err;
      start = (pc >> 2) % 4;
      for (int k = 0; k < 4; k++) d[k] = $urandom;
      for (int k = 0; k < 4; k++) w[(start + k) % 4] = d[k];
      exp_line = {w[3], w[2], w[1], w[0]};
      err = (r0 != 2'b00) || (r2 != 2'b00);
      killed = (flush_at != -1);
      w0 = wen_cnt;
      x0 = xfer_cnt;
      ready_post_i = (stall < 0);

      chk("miss_idle_ready", ready_pre_o, 1);
      valid_pre_i = 1; pc_i = pc; hit_i = 0;
      hit_line_i = {$urandom, $urandom, $urandom, $urandom};
      tick;
      valid_pre_i = 0; hit_line_i = '0;
      #1;
      chk("ar_valid", arvalid, 1);
      chk("ar_addr", araddr, pc & 32'hffff_fffc);
      chk("ar_len", arlen, 3);
      chk("ar_size", arsize, 3'b010);
      chk("ar_burst", arburst, 2'b10);
      chk("ar_id", arid, 0);
      chk("miss_busy", ready_pre_o, 0);
      for (int i = 0; i < ar_wait; i++) begin
         if (i == 0 && flush_at == -2) flush_i = 1;
         tick;
         flush_i = 0;
         #1 chk("ar_hold", arvalid, 1);
      end
      arready = 1;
      exp_way = lfsr_m[2:0];
      lfsr_m = lfsr_next(lfsr_m);
      tick;
      arready = 0;
      #1;
      chk("ar_dropped", arvalid, 0);
      chk("ar_addr_idle", araddr, 0);

      for (int k = 0; k < 4; k++) begin
         if (!killed && k > 0 && $urandom_range(0, 3) == 0) tick;
         rvalid = 1; rdata = d[k]; rlast = (k == 3);
         rresp = (k == 0) ? r0 : ((k == 2) ? r2 : 2'b00);
         if (k == flush_at) flush_i = 1;
         #1;
         chk("r_ready", rready, 1);
         if (killed) chk("drain_no_valid", valid_post_o, 0);
         tick;
         rvalid = 0; rlast = 0; rresp = 0; flush_i = 0;
         #1;
         if (!killed && k == 0) begin
            chk("first_valid", valid_post_o, 1);
            chk("first_inst", inst_o, d[0]);
            chk("first_fault", fault_o, r0 != 2'b00);
         end
      end

      // cycle after rlast
      if (killed) begin
         chk("drain_idle", ready_pre_o, 1);
         chk("drain_no_wen", wen_o, 0);
      end else begin
         chk("wen_after_last", wen_o, !err);
         if (!err) begin
            chk("wdata", wdata_o, exp_line);
            chk("windex", windex_o, pc[7:4]);
            chk("wtag", wtag_o, pc[31:8]);
            chk("wway", wway_o, exp_way);
         end
         if (stall >= 0) begin
            for (int i = 0; i < stall; i++) begin
               chk("stall_valid", valid_post_o, 1);
               chk("stall_inst", inst_o, d[0]);
               chk("stall_pc", pc_o, pc);
               tick;
            end
            ready_post_i = 1;
            #1 chk("stall_release_valid", valid_post_o, 1);
            tick;
         end
      end
      n = 0;
      while (!ready_pre_o && n < 10) begin
         tick;
         n++;
      end
      chk("return_idle", ready_pre_o, 1);
      chk("wen_pulses", wen_cnt - w0, (killed || err) ? 0 : 1);
      chk("xfer_count", xfer_cnt - x0, killed ? 0 : 1);
   endtask

   initial begin
      logic [31:0] pc;
      int aw, st;
      logic [1:0] r2;

      #2 reset = 1;
      @(posedge clock);
      #2;
      chk("rst_ready_pre", ready_pre_o, 1);
      chk("rst_valid_post", valid_post_o, 0);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_wen", wen_o, 0);
      chk("rst_pc", pc_o, 0);
      chk("rst_inst", inst_o, 0);
      chk("rst_fault", fault_o, 0);
      @(negedge clock);
      reset = 0;
      tick;

      do_hit(32'h8000_0008, 0, 0);
      do_hit($urandom & 32'hffff_fffc, 3, 0);
      do_hit($urandom & 32'hffff_fffc, 0, 1);

      do_miss(32'h8000_0018, 3, -1, 2'b00, 2'b00, -1);
      do_miss($urandom & 32'hffff_fffc, 0, -1, 2'b00, 2'b00, 5);
      do_miss($urandom & 32'hffff_fffc, 1, 1, 2'b00, 2'b00, -1);
      do_miss($urandom & 32'hffff_fffc, 0, -1, 2'b10, 2'b00, -1);
      do_miss($urandom & 32'hffff_fffc, 0, -1, 2'b00, 2'b10, -1);
      do_miss($urandom & 32'hffff_fffc, 2, -2, 2'b00, 2'b00, -1);

      for (int i = 0; i < 8; i++) begin
         pc = $urandom & 32'hffff_fffc;
         aw = $urandom_range(0, 3);
         st = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 4));
         r2 = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
         do_miss(pc, aw, -1, 2'b00, r2, st);
         if ($urandom_range(0, 1) == 0) do_hit($urandom & 32'hffff_fffc, $urandom_range(0, 2), 0);
      end

      // reset while a refill is mid-burst
      ready_post_i = 0;
      valid_pre_i = 1; pc_i = 32'h1234_5670; hit_i = 0;
      tick;
      valid_pre_i = 0;
      arready = 1;
      tick;
      arready = 0;
      rvalid = 1; rdata = 32'hdead_beef; rresp = 0; rlast = 0;
      tick;
      rvalid = 0;
      #1 chk("pre_reset_valid", valid_post_o, 1);
      #1 reset = 1;
      #1;
      chk("midr_ready_pre", ready_pre_o, 1);
      chk("midr_valid_post", valid_post_o, 0);
      chk("midr_rready", rready, 0);
      chk("midr_arvalid", arvalid, 0);
      chk("midr_pc", pc_o, 0);
      chk("midr_inst", inst_o, 0);
      chk("midr_wen", wen_o, 0);
      lfsr_m = 8'h01;
      @(negedge clock);
      reset = 0;
      tick;
      do_miss($urandom & 32'hffff_fffc, 1, -1, 2'b00, 2'b00, -1);
      do_miss($urandom & 32'hffff_fffc, 0, -1, 2'b00, 2'b00, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
